// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
// Pipelined carry-lookahead adder/subtractor. The operands are cut into
// STAGES slices of SLICE = WIDTH/STAGES bits. Stage k adds slice k with
// 4-bit CLA groups and registers the carry that stage k+1 consumes. One
// operation can be accepted per cycle. The result appears STAGES cycles
// after acceptance. A single global stall freezes the whole pipe while
// a finished result waits for the consumer.
//
// Parameters
//   WIDTH   operand/result width. It must be divisible by STAGES.
//   STAGES  number of pipeline stages. WIDTH/STAGES must be a multiple of 4.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears valids, S, Cout, Ovf)
//   in_valid   operand set presented
//   in_ready   operands accepted this cycle (equals the pipe advance)
//   A, B       operands
//   Cin        carry-in when adding, borrow-in when subtracting
//   sub        0: A+B+Cin, 1: A-B-Cin
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   S          result modulo 2^WIDTH
//   Cout       raw carry out of the MSB (1 = no borrow when subtracting)
//   Ovf        two's-complement signed overflow
module pipelined_cla_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int NGRP  = SLICE / 4;
    localparam int WW    = 2 * WIDTH;

    // Each stage word is {b', a/sum}. The lower half holds finished sum
    // slices below the current stage and raw A slices above it. This
    // arrangement gives the skew and the deskew with one register word. The
    // b' bits of finished slices are cleared to zero so they never toggle.

    // 4-bit lookahead group: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       gg;
        logic       pp;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        pp   = &p;
        return {gg | (pp & ci), p ^ c};
    endfunction

    // One slice: group generate/propagate ripple between the 4-bit groups
    function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic             ci);
        logic [SLICE-1:0] sum;
        logic             c;
        logic [4:0]       r;
        sum = {SLICE{1'b0}};
        c   = ci;
        for (int gi = 0; gi < NGRP; gi++) begin
            r               = cla4(a[gi*4 +: 4], b[gi*4 +: 4], c);
            sum[gi*4 +: 4]  = r[3:0];
            c               = r[4];
        end
        return {c, sum};
    endfunction

    logic             v_r   [STAGES];
    logic [WW-1:0]    w_r   [STAGES];
    logic             c_r   [STAGES];
    logic             ovf_r;

    logic             stg_v_s [STAGES];
    logic [WW-1:0]    stg_w_s [STAGES];
    logic             stg_c_s [STAGES];
    logic [WW-1:0]    nxt_w_s [STAGES];
    logic             nxt_c_s [STAGES];
    logic             nxt_ovf_s;
    logic             advance_s;
    logic [WIDTH-1:0] b_x_s;
    logic             c0_s;

    // Operand transform at capture: subtract adds the inverted B and the inverted borrow
    always_comb begin
        if (sub) begin
            b_x_s = ~B;
            c0_s  = ~Cin;
        end else begin
            b_x_s = B;
            c0_s  = Cin;
        end
    end

    // Stage inputs: stage 0 takes the live operands, stage k the register of stage k-1
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stg_v_s[k] = 1'b0;
            stg_w_s[k] = {WW{1'b0}};
            stg_c_s[k] = 1'b0;
        end
        stg_v_s[0] = in_valid;
        stg_w_s[0] = {b_x_s, A};
        stg_c_s[0] = c0_s;
        for (int k = 1; k < STAGES; k++) begin
            stg_v_s[k] = v_r[k-1];
            stg_w_s[k] = w_r[k-1];
            stg_c_s[k] = c_r[k-1];
        end
    end

    // Per-stage slice addition plus the MSB flags of the last stage
    always_comb begin
        logic [SLICE-1:0] a_sl;
        logic [SLICE-1:0] b_sl;
        logic [SLICE:0]   r_sl;
        logic             c_msb;
        a_sl = {SLICE{1'b0}};
        b_sl = {SLICE{1'b0}};
        r_sl = {(SLICE+1){1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            a_sl       = stg_w_s[k][k*SLICE +: SLICE];
            b_sl       = stg_w_s[k][WIDTH + k*SLICE +: SLICE];
            r_sl       = cla_slice(a_sl, b_sl, stg_c_s[k]);
            nxt_w_s[k] = stg_w_s[k];
            nxt_w_s[k][k*SLICE +: SLICE]         = r_sl[SLICE-1:0];
            nxt_w_s[k][WIDTH + k*SLICE +: SLICE] = {SLICE{1'b0}};
            nxt_c_s[k] = r_sl[SLICE];
        end
        // Carry into the MSB is recovered from its sum bit: s = a ^ b ^ c_in
        c_msb     = stg_w_s[STAGES-1][WIDTH-1] ^ stg_w_s[STAGES-1][WW-1]
                  ^ nxt_w_s[STAGES-1][WIDTH-1];
        nxt_ovf_s = c_msb ^ nxt_c_s[STAGES-1];
    end

    // Global stall: the whole pipe moves only when the output slot is free or drained
    always_comb begin
        advance_s = ~v_r[STAGES-1] | out_ready;
    end

    // Pipeline registers. Reset clears everything. A stall holds every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= 1'b0;
                w_r[k] <= {WW{1'b0}};
                c_r[k] <= 1'b0;
            end
            ovf_r <= 1'b0;
        end else if (advance_s) begin
            for (int k = 0; k < STAGES; k++) begin
                v_r[k] <= stg_v_s[k];
                w_r[k] <= nxt_w_s[k];
                c_r[k] <= nxt_c_s[k];
            end
            ovf_r <= nxt_ovf_s;
        end
    end

    assign in_ready  = advance_s;
    assign out_valid = v_r[STAGES-1];
    assign S         = w_r[STAGES-1][WIDTH-1:0];
    assign Cout      = c_r[STAGES-1];
    assign Ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: a default 16-bit/4-stage instance
// and a 4-bit/1-stage instance, with hand-computed expected results.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit, 4-stage instance
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    // 4-bit, 1-stage instance
    logic        in_valid_n;
    logic        in_ready_n;
    logic [3:0]  a_n;
    logic [3:0]  b_n;
    logic        cin_n;
    logic        sub_n;
    logic        out_valid_n;
    logic        out_ready_n;
    logic [3:0]  s_n;
    logic        cout_n;
    logic        ovf_n;

    int n_tests = 0;
    int n_fail  = 0;

    pipelined_cla_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .Cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .S(s), .Cout(cout), .Ovf(ovf)
    );

    pipelined_cla_adder #(.WIDTH(4), .STAGES(1)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready_n),
        .A(a_n), .B(b_n), .Cin(cin_n), .sub(sub_n), .out_valid(out_valid_n),
        .out_ready(out_ready_n), .S(s_n), .Cout(cout_n), .Ovf(ovf_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic sv);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = cv;
        sub      = sv;
    endtask

    // Single operation through the empty pipe; the result must arrive exactly 4 cycles later
    task automatic send_one(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic cv, input logic sv, input logic [15:0] es,
                            input logic ec, input logic eo);
        out_ready = 1'b1;
        drive(av, bv, cv, sv);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq({tag, "_early"}, {31'd0, out_valid}, 32'd0);
            tick();
        end
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_s"}, {16'd0, s}, {16'd0, es});
        check_eq({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check_eq({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        a           = 16'h0000;
        b           = 16'h0000;
        cin         = 1'b0;
        sub         = 1'b0;
        out_ready   = 1'b1;
        in_valid_n  = 1'b0;
        a_n         = 4'h0;
        b_n         = 4'h0;
        cin_n       = 1'b0;
        sub_n       = 1'b0;
        out_ready_n = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_s", {16'd0, s}, 32'd0);
        check_eq("rst_cout", {31'd0, cout}, 32'd0);
        check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_valid_n", {31'd0, out_valid_n}, 32'd0);

        // Single-stage 4-bit instance: latency 1
        in_valid_n = 1'b1;
        a_n = 4'b1111;
        b_n = 4'b1111;
        cin_n = 1'b0;
        tick();
        check_eq("w4_a_valid", {31'd0, out_valid_n}, 32'd1);
        check_eq("w4_a_s", {28'd0, s_n}, 32'he);
        check_eq("w4_a_cout", {31'd0, cout_n}, 32'd1);
        check_eq("w4_a_ovf", {31'd0, ovf_n}, 32'd0);
        a_n = 4'b1001;
        b_n = 4'b0001;
        cin_n = 1'b1;
        tick();
        in_valid_n = 1'b0;
        check_eq("w4_b_valid", {31'd0, out_valid_n}, 32'd1);
        check_eq("w4_b_s", {28'd0, s_n}, 32'hb);
        check_eq("w4_b_cout", {31'd0, cout_n}, 32'd0);
        check_eq("w4_b_ovf", {31'd0, ovf_n}, 32'd0);
        tick();
        check_eq("w4_drain", {31'd0, out_valid_n}, 32'd0);

        // Carry chains, overflow and subtract on the 4-stage instance
        send_one("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_one("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_one("0fff_cin", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
        send_one("sub_9_1", 16'h0009, 16'h0001, 1'b0, 1'b1, 16'h0008, 1'b1, 1'b0);
        send_one("sub_0_1", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        send_one("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send_one("sub_borrow", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);

        // Streaming: four back-to-back ops, results on four consecutive cycles
        out_ready = 1'b1;
        drive(16'd1, 16'd1, 1'b0, 1'b0);
        tick();
        drive(16'd2, 16'd2, 1'b0, 1'b0);
        tick();
        drive(16'd3, 16'd3, 1'b0, 1'b0);
        tick();
        check_eq("strm_early", {31'd0, out_valid}, 32'd0);
        drive(16'd4, 16'd4, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("strm_valid", {31'd0, out_valid}, 32'd1);
            check_eq("strm_s", {16'd0, s}, 32'(2 * (i + 1)));
            tick();
        end
        check_eq("strm_end", {31'd0, out_valid}, 32'd0);

        // Backpressure: fill, stall three cycles, then release with a new op waiting
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(16'(10 * i), 16'(i), 1'b0, 1'b0);
            tick();
        end
        drive(16'd50, 16'd5, 1'b0, 1'b0);
        #1;
        check_eq("bp_ready", {31'd0, in_ready}, 32'd0);
        check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
        check_eq("bp_s", {16'd0, s}, 32'd11);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_hold_s", {16'd0, s}, 32'd11);
            check_eq("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("bp_hold_ready", {31'd0, in_ready}, 32'd0);
            check_eq("bp_hold_flags", {30'd0, cout, ovf}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            check_eq("bp_drain_valid", {31'd0, out_valid}, 32'd1);
            check_eq("bp_drain_s", {16'd0, s}, 32'(11 * i));
            tick();
        end
        check_eq("bp_end", {31'd0, out_valid}, 32'd0);

        // Reset with three ops in flight: nothing stale may come out
        out_ready = 1'b1;
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(16'h0001, 16'h0001, 1'b0, 1'b0);
        tick();
        drive(16'h0002, 16'h0002, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mrst_s", {16'd0, s}, 32'd0);
        check_eq("mrst_cout", {31'd0, cout}, 32'd0);
        check_eq("mrst_ovf", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("mrst_stale", {31'd0, out_valid}, 32'd0);
        end
        send_one("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the team's 4-bit combinational CLA.
- Operands are split into STAGES equal slices. Each pipeline stage adds one slice with 4-bit CLA groups and registers the carry into the next stage.
- Streams one operation per cycle behind a valid/ready handshake. Used as the datapath adder for the upcoming ALU labs.

Parameters:
- WIDTH, 16, operand and result width in bits.
- STAGES, 4, number of pipeline stages. WIDTH must be divisible by STAGES. SLICE = WIDTH/STAGES must be a multiple of 4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block accepts operands this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in (add) / borrow-in (subtract).
- sub  input  1  0 = A+B+Cin; 1 = A-B-Cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- S  output  WIDTH  result, modulo 2^WIDTH.
- Cout  output  1  raw carry out of the MSB. In subtract mode, 1 = no borrow.
- Ovf  output  1  two's-complement signed overflow.

Behaviour:
- One clock; reset is synchronous and active-high. All registers update on rising clk only.
- Reset (rst=1 at a clock edge): every stage valid bit, S, Cout and Ovf clear to 0 on that edge. out_valid=0 from the next cycle; in-flight operations are discarded. rst has priority over all other inputs.
- Internal operand transform at capture: B' = sub ? ~B : B; c0 = sub ? ~Cin : Cin. Then S = A + B' + c0.
- Slice k (k = 0..STAGES-1) covers bits [k*SLICE +: SLICE].
  - Stage k computes slice k from skew-delayed A/B' slices and the carry registered by stage k-1 (stage 0 uses c0).
  - Within a slice: per 4-bit group g_i = a_i&b_i, p_i = a_i^b_i; lookahead carries c_{i+1} = g_i | p_i&c_i expanded per group; group G/P ripple between groups inside the slice.
- Skew/deskew: operand slice k is delayed k registers before stage k. Result slice k is delayed STAGES-1-k registers after it, so all S bits of one operation emerge together.
- Latency: exactly STAGES cycles from an accepted input (in_valid & in_ready at edge t) to out_valid=1 with its result, visible after edge t+STAGES-1. Throughput is 1 op/cycle.
- Flags, computed in the last stage:
  - Cout = carry out of bit WIDTH-1.
  - Ovf = carry into MSB XOR carry out of MSB.
- Handshake, global stall:
  - advance = ~out_valid | out_ready; in_ready = advance.
  - When advance=0, all stage registers, S, Cout, Ovf and out_valid hold.
  - Input accepted only when in_valid & in_ready. With in_valid=0 at an advancing edge, a bubble (valid=0) enters stage 0.
- out_valid, S, Cout and Ovf are stable while out_valid=1 and out_ready=0.
- sub and Cin are captured with A/B. Changing them mid-flight does not affect operations already accepted.
- Simultaneous out_ready=1 and in_valid=1 with a full pipe: one result leaves and one operand enters in the same cycle, with no bubble.
- Boundary case STAGES=1: a single registered stage, latency 1; the skew chains have length 0.

Test Plan:
1. WIDTH=4, STAGES=1: A=4'b1111, B=4'b1111, Cin=0, sub=0 -> after 1 cycle S=4'b1110, Cout=1, Ovf=0. Then A=4'b1001, B=4'b0001, Cin=1 -> S=4'b1011, Cout=0, Ovf=0.
2. Defaults, add carry chain across all slices: A=16'hFFFF, B=16'h0001, Cin=0 -> out_valid exactly 4 cycles after acceptance, S=16'h0000, Cout=1, Ovf=0.
3. Signed overflow and subtract:
   - A=16'h7FFF + B=16'h0001 -> S=16'h8000, Ovf=1, Cout=0.
   - sub=1, A=16'h0009, B=16'h0001, Cin=0 -> S=16'h0008, Cout=1.
   - sub=1, A=16'h0000, B=16'h0001 -> S=16'hFFFF, Cout=0, Ovf=0.
4. Streaming: ops 1+1, 2+2, 3+3, 4+4 on consecutive cycles with out_ready=1 -> results 2, 4, 6, 8 in order on 4 consecutive cycles, the first 4 cycles after the first acceptance.
5. Backpressure: fill the pipe, hold out_ready=0 for 3 cycles -> in_ready=0, S/Cout/Ovf/out_valid frozen. Release out_ready -> all results delivered in order with none lost or duplicated.
6. Reset mid-operation: 3 ops in flight, assert rst for one edge -> out_valid=0, S=0, Cout=0, Ovf=0 next cycle. No stale result ever appears; a new op after reset returns its correct result after 4 cycles.
